// File: rtl/pixel_prefetch_fifo.sv
// rtl/pixel_prefetch_fifo.sv - show-ahead pixel buffer between frame decoder and LCD timing generator
// Tracks per-frame pop count, flags underflow, and is emptied by the end-of-frame flush pulse.
module pixel_prefetch_fifo #(
  parameter int               WIDTH           = 32,
  parameter int               DEPTH           = 16,
  parameter int               FRAME_PIXELS    = 384000,
  parameter logic [WIDTH-1:0] UNDERFLOW_COLOR = 32'h00FF00FF
) (
  input  logic                     iCLK,
  input  logic                     iRST_n,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_color,
  output logic                     in_ready,
  input  logic                     pixel_read_next,
  input  logic                     frame_flush,
  output logic [WIDTH-1:0]         out_color,
  output logic                     out_valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     underflow,
  output logic                     frame_done
);

  localparam int PW     = $clog2(DEPTH);
  localparam int LW     = PW + 1;
  localparam int CW_MIN = $clog2(FRAME_PIXELS + 1);
  localparam int CW     = (CW_MIN < 19) ? 19 : CW_MIN;

  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [CW-1:0] FRAME_L = CW'(FRAME_PIXELS);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [LW-1:0]    level_next;
  logic [CW-1:0]    pix_cnt;
  logic             push;
  logic             pop;
  logic             cnt_step;
  logic             cnt_last;

  assign out_valid = (level != '0);
  assign push      = in_valid & in_ready & ~frame_flush;
  assign pop       = pixel_read_next & out_valid & ~frame_flush;
  assign cnt_step  = pixel_read_next & (pix_cnt != FRAME_L);
  assign cnt_last  = cnt_step & ((pix_cnt + CW'(1)) == FRAME_L);

  // Head word comes straight from the registered read pointer; an empty pop shows the marker colour.
  always_comb begin
    out_color = '0;
    if (out_valid)
      out_color = mem[rd_ptr];
    else if (pixel_read_next)
      out_color = UNDERFLOW_COLOR;
  end

  always_comb begin
    level_next = level;
    if (push && !pop)
      level_next = level + LW'(1);
    else if (pop && !push)
      level_next = level - LW'(1);
  end

  // Storage is never reset; out_valid=0 keeps stale words hidden.
  always_ff @(posedge iCLK) begin
    if (push)
      mem[wr_ptr] <= in_color;
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      in_ready   <= 1'b0;
      underflow  <= 1'b0;
      frame_done <= 1'b0;
      pix_cnt    <= '0;
    end else if (frame_flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      in_ready   <= 1'b1;
      underflow  <= 1'b0;
      frame_done <= 1'b0;
      pix_cnt    <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      level      <= level_next;
      in_ready   <= (level_next < DEPTH_L);
      underflow  <= underflow | (pixel_read_next & ~out_valid);
      frame_done <= cnt_last;
      if (cnt_step)
        pix_cnt <= pix_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_pixel_prefetch_fifo.sv
// tb/tb_pixel_prefetch_fifo.sv - directed scoreboard bench for pixel_prefetch_fifo
// Frame length is shortened so the frame_done boundary is reachable in a short run.
module tb_pixel_prefetch_fifo;

  localparam int          DEPTH = 16;
  localparam int          FP    = 40;
  localparam logic [31:0] UF    = 32'h00FF00FF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_color = '0;
  logic        in_ready;
  logic        pixel_read_next = 1'b0;
  logic        frame_flush = 1'b0;
  logic [31:0] out_color;
  logic        out_valid;
  logic [4:0]  level;
  logic        underflow;
  logic        frame_done;

  always #5 clk = ~clk;

  pixel_prefetch_fifo #(
    .WIDTH(32), .DEPTH(DEPTH), .FRAME_PIXELS(FP), .UNDERFLOW_COLOR(UF)
  ) dut (
    .iCLK(clk), .iRST_n(rst_n),
    .in_valid(in_valid), .in_color(in_color), .in_ready(in_ready),
    .pixel_read_next(pixel_read_next), .frame_flush(frame_flush),
    .out_color(out_color), .out_valid(out_valid), .level(level),
    .underflow(underflow), .frame_done(frame_done)
  );

  logic [31:0] sb[$];
  int          m_cnt = 0;
  bit          m_ready = 1'b0;
  bit          m_uf = 1'b0;
  bit          m_fd = 1'b0;
  bit          last_push = 1'b0;
  int          errors = 0;
  int          checks = 0;
  int          fd_seen = 0;
  logic [31:0] nd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic post_checks();
    chk("level", 32'(level), 32'(sb.size()));
    chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
    chk("in_ready", 32'(in_ready), 32'(m_ready));
    chk("underflow", 32'(underflow), 32'(m_uf));
    chk("frame_done", 32'(frame_done), 32'(m_fd));
    if (sb.size() != 0)
      chk("head_color", out_color, sb[0]);
  endtask

  task automatic model_reset();
    sb.delete();
    m_cnt   = 0;
    m_ready = 1'b0;
    m_uf    = 1'b0;
    m_fd    = 1'b0;
  endtask

  // One clock: drive, check the show-ahead word before the edge, then update the model and check after it.
  task automatic cyc(input bit v, input logic [31:0] c, input bit rd, input bit fl);
    bit push;
    bit pop;
    bit empty;
    in_valid        = v;
    in_color        = c;
    pixel_read_next = rd;
    frame_flush     = fl;
    #1;
    empty = (sb.size() == 0);
    if (rd)
      chk("pop_color", out_color, empty ? UF : sb[0]);
    push = v && m_ready && !fl;
    pop  = rd && !empty && !fl;
    @(posedge clk);
    #1;
    if (fl) begin
      sb.delete();
      m_cnt   = 0;
      m_uf    = 1'b0;
      m_fd    = 1'b0;
      m_ready = 1'b1;
    end else begin
      if (pop)
        void'(sb.pop_front());
      if (push)
        sb.push_back(c);
      if (rd && empty)
        m_uf = 1'b1;
      m_fd = rd && (m_cnt != FP) && (m_cnt + 1 == FP);
      if (rd && m_cnt != FP)
        m_cnt++;
      m_ready = (sb.size() < DEPTH);
    end
    last_push = push;
    fd_seen += int'(frame_done);
    post_checks();
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_level"}, 32'(level), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_out_color"}, out_color, 32'd0);
    chk({tag, "_underflow"}, 32'(underflow), 32'd0);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    reset_checks("rst");
    rst_n = 1'b1;
    model_reset();
    cyc(0, '0, 0, 0);

    // 1: fill to DEPTH, then one extra offered word that must be refused
    for (int i = 1; i <= DEPTH; i++)
      cyc(1, 32'(i), 0, 0);
    chk("full_level", 32'(level), 32'd16);
    chk("full_ready", 32'(in_ready), 32'd0);
    chk("full_head", out_color, 32'h1);
    cyc(1, 32'hDEAD, 0, 0);

    // 2: concurrent push/pop from full
    nd = 32'd17;
    for (int i = 0; i < 20; i++) begin
      cyc(1, nd, 1, 0);
      if (last_push)
        nd++;
    end
    for (int k = 0; k < 40 && sb.size() > 0; k++)
      cyc(0, '0, 1, 0);
    chk("drained", 32'(level), 32'd0);

    // 3: empty pop, then a fresh word shows ahead one cycle after its push
    cyc(0, '0, 1, 0);
    chk("uf_sticky", 32'(underflow), 32'd1);
    cyc(1, 32'h00ABCDEF, 0, 0);
    chk("after_uf_head", out_color, 32'h00ABCDEF);
    cyc(0, '0, 1, 0);

    // 4: one full frame of steady push+pop, plus extra pops past the end
    cyc(0, '0, 0, 1);
    fd_seen = 0;
    cyc(1, 32'h100, 0, 0);
    nd = 32'h101;
    for (int i = 0; i < FP + 5; i++) begin
      cyc(1, nd, 1, 0);
      if (last_push)
        nd++;
    end
    chk("fd_once", 32'(fd_seen), 32'd1);
    chk("frame_uf", 32'(underflow), 32'd0);

    // 5: flush at level 7 with coincident push and pop
    cyc(0, '0, 0, 1);
    for (int i = 0; i < 7; i++)
      cyc(1, 32'h700 + 32'(i), 0, 0);
    chk("lvl7", 32'(level), 32'd7);
    cyc(1, 32'h00777777, 1, 1);
    chk("flush_level", 32'(level), 32'd0);
    cyc(1, 32'h55, 0, 0);
    chk("flush_dropped", out_color, 32'h55);
    fd_seen = 0;
    nd = 32'h56;
    for (int i = 0; i < FP; i++) begin
      cyc(1, nd, 1, 0);
      if (last_push)
        nd++;
    end
    chk("fd_after_flush", 32'(fd_seen), 32'd1);

    // 6: asynchronous reset between edges mid-burst
    for (int i = 0; i < 3; i++)
      cyc(1, 32'hA0 + 32'(i), 0, 0);
    in_valid        = 1'b1;
    pixel_read_next = 1'b0;
    frame_flush     = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    reset_checks("async");
    model_reset();
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    chk("rel_ready0", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("rel_ready1", 32'(in_ready), 32'd1);
    m_ready = 1'b1;
    cyc(1, 32'h00C0FFEE, 0, 0);
    cyc(1, 32'h00C0FFEF, 1, 0);
    cyc(0, '0, 1, 0);
    cyc(0, '0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pixel_prefetch_fifo.md
Name: pixel_prefetch_fifo

Overview:
- Show-ahead pixel buffer between the compressed-frame decoder (producer) and the LCD timing generator (consumer).
- Absorbs the decoder's variable per-pixel latency, e.g. RAM read stalls and chunk boundaries, so the display can pop one pixel per active clock.
- Tracks per-frame pixel count, flags underflow, and is flushed at every frame boundary.

Parameters:
- WIDTH, 32, pixel word width (0x00RRGGBB).
- DEPTH, 16, number of entries; power of two, at least 4.
- FRAME_PIXELS, 384000, pixels per frame (800*480).
- UNDERFLOW_COLOR, 32'h00FF00FF, word presented when a pop hits an empty buffer.

Ports:
- iCLK  in  1  clock; all logic on rising edge.
- iRST_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  producer has a pixel on in_color.
- in_color  in  WIDTH  producer pixel.
- in_ready  out  1  buffer accepts in_color this cycle.
- pixel_read_next  in  1  consumer pops the head pixel this cycle (display active).
- frame_flush  in  1  single-cycle end-of-frame pulse; empties buffer and clears frame state.
- out_color  out  WIDTH  head pixel, valid whenever out_valid=1.
- out_valid  out  1  buffer non-empty.
- level  out  $clog2(DEPTH)+1  current occupancy.
- underflow  out  1  sticky; a pop occurred while empty in this frame.
- frame_done  out  1  one-cycle pulse when the FRAME_PIXELS-th pop completes.

Behaviour:
- Reset values, applied asynchronously while iRST_n=0:
  - read and write pointers 0, level=0, out_valid=0, in_ready=0.
  - out_color=0, underflow=0, frame_done=0, pixel counter 0.
- in_ready is registered:
  - 1 from the first clock after reset release when level<DEPTH.
  - It equals (level_next < DEPTH) computed from the current-cycle push/pop.
- A push occurs on (in_valid & in_ready). in_color is written at the write pointer, which then increments modulo DEPTH.
- A pop occurs on (pixel_read_next & out_valid). The read pointer increments modulo DEPTH.
- out_color is show-ahead:
  - It presents the storage entry at the read pointer combinationally from a registered pointer, with no extra latency.
  - First-pixel latency: a push at edge N makes out_valid=1 and out_color valid after edge N.
- Simultaneous push and pop: level is unchanged. This is allowed when full, but in_ready was already 0, so no push can occur. It is also allowed when level=1.
- Empty pop (pixel_read_next & ~out_valid):
  - out_color shows UNDERFLOW_COLOR during that cycle.
  - underflow is set at the next edge.
  - The pixel counter still increments, so the display stays aligned.
- Pixel counter:
  - 19+ bits; counts every cycle with pixel_read_next=1.
  - On the increment that reaches FRAME_PIXELS, frame_done pulses the next cycle and the counter holds at FRAME_PIXELS.
  - Further pops do not re-pulse frame_done and do not overflow the counter.
- frame_flush, which has priority over push and pop in the same cycle:
  - Next edge: pointers=0, level=0, out_valid=0, counter=0, underflow=0, frame_done=0.
  - in_ready=1 the cycle after the flush.
  - Any push coincident with the flush is dropped; the producer is reset by the same pulse.
- Reset mid-operation: asynchronous clear of all state. Storage contents are don't-care and are never exposed, because out_valid=0.
- Width rules:
  - level is one bit wider than the pointers, so full (DEPTH) is distinct from empty (0).
  - The pointers wrap with no explicit compare.

Test Plan:
1. Reset, then push 0x000001..0x000010 with no pops -> level=16, in_ready=0 after the 16th push, out_color=0x000001, out_valid=1.
2. Full buffer, then assert pixel_read_next and in_valid together for 20 cycles with sequential data -> out_color sequence is 1,2,3,… with no gaps or duplicates; level stays within 15..16; no underflow.
3. Empty buffer, then a single pixel_read_next pulse -> out_color=0x00FF00FF that cycle, underflow=1 next cycle; the next push of 0xABCDEF appears on out_color one cycle later.
4. Steady 1 push + 1 pop per cycle for FRAME_PIXELS pops -> frame_done is high exactly once, one cycle after pop 384000; counter holds; underflow=0.
5. level=7 with frame_flush, in_valid and pixel_read_next all high in one cycle -> next cycle level=0, out_valid=0, underflow=0, counter=0; the coincident pixel is not stored.
6. Drop iRST_n asynchronously mid-burst, between clock edges -> all outputs go to their reset values immediately; after release, in_ready=1 on the first edge and normal operation resumes from empty.
